// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared types and defaults for the GPS UART transmit arbiter
package gps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_HOST = 2'b01;
    localparam logic [1:0] GRANT_RTK  = 2'b10;

    // 100 MHz / 38400 baud, truncated
    localparam int DEF_CLKS_PER_BIT = 2604;
    localparam int DEF_GAP_CLKS     = 100000;

endpackage

// File: rtl/gps_uart_tx.sv
// rtl/gps_uart_tx.sv - 8N1 UART serializer with registered line output
module gps_uart_tx
    import gps_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_q;
    logic [8:0]       shreg_q;
    logic             busy_q;
    logic             tx_q;

    assign busy = busy_q;
    assign tx   = tx_q;
    // done marks the final cycle of the stop bit
    assign done = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '1;
        end else if (!busy_q) begin
            if (load) begin
                busy_q  <= 1'b1;
                tx_q    <= 1'b0;
                cnt_q   <= '0;
                bit_q   <= '0;
                shreg_q <= {1'b1, data};
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                bit_q   <= bit_q + 4'd1;
                tx_q    <= shreg_q[0];
                shreg_q <= {1'b1, shreg_q[8:1]};
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/gps_tx_arbiter.sv
// rtl/gps_tx_arbiter.sv - frame-atomic round-robin arbiter feeding the receiver UART
module gps_tx_arbiter
    import gps_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int GAP_CLKS     = DEF_GAP_CLKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    input  logic       host_last,
    output logic       host_ready,
    input  logic [7:0] rtk_data,
    input  logic       rtk_valid,
    input  logic       rtk_last,
    output logic       rtk_ready,
    output logic       gps_tx,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    state_t           state_q;
    logic [1:0]       grant_q;
    logic             host_next_q;
    logic [GAP_W-1:0] gap_q;
    logic             last_q;
    logic             timeout_q;

    logic       uart_busy;
    logic       uart_done;
    logic       hs;
    logic       sel_last;
    logic [7:0] sel_data;

    assign host_ready  = (state_q == ST_LOAD) && (grant_q == GRANT_HOST) && !uart_busy;
    assign rtk_ready   = (state_q == ST_LOAD) && (grant_q == GRANT_RTK) && !uart_busy;
    assign hs          = (host_valid && host_ready) || (rtk_valid && rtk_ready);
    assign sel_data    = (grant_q == GRANT_RTK) ? rtk_data : host_data;
    assign sel_last    = (grant_q == GRANT_RTK) ? rtk_last : host_last;
    assign grant       = grant_q;
    assign busy        = (grant_q != GRANT_NONE);
    assign timeout_err = timeout_q;

    gps_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .reset(reset),
        .load (hs),
        .data (sel_data),
        .busy (uart_busy),
        .done (uart_done),
        .tx   (gps_tx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= GRANT_NONE;
            host_next_q <= 1'b1;
            gap_q       <= '0;
            last_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gap_q <= '0;
                    if (host_valid && (host_next_q || !rtk_valid)) begin
                        grant_q <= GRANT_HOST;
                        state_q <= ST_LOAD;
                    end else if (rtk_valid) begin
                        grant_q <= GRANT_RTK;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        last_q  <= sel_last;
                        gap_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else if (gap_q == GAP_LAST) begin
                        // a stalled owner loses the line and yields the next tie
                        timeout_q   <= 1'b1;
                        grant_q     <= GRANT_NONE;
                        host_next_q <= (grant_q == GRANT_RTK);
                        gap_q       <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (uart_done) begin
                        if (last_q) begin
                            grant_q     <= GRANT_NONE;
                            host_next_q <= (grant_q == GRANT_RTK);
                            state_q     <= ST_IDLE;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
